// File: rtl/vga_text_console.sv
`default_nettype none
// ============================================================================
//  Module      : vga_text_console
//  Description : Write-side sequencer for the text-mode character RAM. It
//                takes a byte stream over a valid/ready handshake and keeps a
//                cursor. Printable and control codes become single cell
//                writes. It also runs line-clear and full-screen-clear sweeps.
//                Everything runs in the pixel clock domain.
//  Ports       : clk, reset        - pixel clock, synchronous active-high reset
//                char_in/valid/ready - byte input handshake
//                clear_req         - single-cycle full-screen clear request
//                addr_write, data_write, write_enable - character RAM port
//                cursor_x, cursor_y - current cursor position
//                busy              - high whenever the sequencer is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_text_console #(
    parameter int COLS       = 160,
    parameter int ROWS       = 128,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            char_in,
    input  logic                  char_valid,
    output logic                  char_ready,
    input  logic                  clear_req,
    output logic [ADDR_WIDTH-1:0] addr_write,
    output logic [7:0]            data_write,
    output logic                  write_enable,
    output logic [7:0]            cursor_x,
    output logic [6:0]            cursor_y,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] C_COLS      = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] C_LAST_COL  = ADDR_WIDTH'(COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] C_LAST_CELL = ADDR_WIDTH'(COLS * ROWS - 1);
    localparam logic [7:0]            C_X_MAX     = 8'(COLS - 1);
    localparam logic [6:0]            C_Y_MAX     = 7'(ROWS - 1);
    localparam logic [7:0]            C_SPACE     = 8'h20;
    localparam logic [7:0]            C_LF        = 8'h0A;
    localparam logic [7:0]            C_CR        = 8'h0D;
    localparam logic [7:0]            C_BS        = 8'h08;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_CLR_LINE = 2'd2,
        S_CLR_ALL  = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;   // sweep position within the current clear
    logic                  r_wrap;  // the pending WRITE came from the last column

    logic [6:0]            w_y_next;
    logic [ADDR_WIDTH-1:0] w_row_base;
    logic [ADDR_WIDTH-1:0] w_next_row_base;
    logic [ADDR_WIDTH-1:0] w_cur_addr;
    logic                  w_accept;
    logic                  w_printable;

    // Rows wrap instead of scrolling. The row entered is then blanked.
    assign w_y_next        = (cursor_y == C_Y_MAX) ? 7'd0 : cursor_y + 7'd1;
    assign w_row_base      = ADDR_WIDTH'(cursor_y) * C_COLS;
    assign w_next_row_base = ADDR_WIDTH'(w_y_next) * C_COLS;
    assign w_cur_addr      = w_row_base + ADDR_WIDTH'(cursor_x);
    // A clear request in the same cycle takes priority, and the byte is left pending.
    assign w_accept        = char_valid && char_ready && !clear_req;
    assign w_printable     = (char_in >= 8'h20) && (char_in <= 8'h7E);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wrap       <= 1'b0;
            cursor_x     <= 8'd0;
            cursor_y     <= 7'd0;
            write_enable <= 1'b0;
            addr_write   <= '0;
            data_write   <= 8'd0;
            char_ready   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    write_enable <= 1'b0;
                    if (clear_req) begin
                        r_state      <= S_CLR_ALL;
                        r_cnt        <= '0;
                        write_enable <= 1'b1;
                        addr_write   <= '0;
                        data_write   <= C_SPACE;
                        char_ready   <= 1'b0;
                        busy         <= 1'b1;
                    end else if (w_accept) begin
                        // Every accepted byte costs at least one cycle with char_ready low.
                        char_ready <= 1'b0;
                        if (w_printable) begin
                            r_state      <= S_WRITE;
                            write_enable <= 1'b1;
                            addr_write   <= w_cur_addr;
                            data_write   <= char_in;
                            busy         <= 1'b1;
                            r_wrap       <= (cursor_x == C_X_MAX);
                            if (cursor_x == C_X_MAX) begin
                                cursor_x <= 8'd0;
                                cursor_y <= w_y_next;
                            end else begin
                                cursor_x <= cursor_x + 8'd1;
                            end
                        end else if (char_in == C_LF) begin
                            r_state      <= S_CLR_LINE;
                            r_cnt        <= '0;
                            write_enable <= 1'b1;
                            addr_write   <= w_next_row_base;
                            data_write   <= C_SPACE;
                            busy         <= 1'b1;
                            cursor_x     <= 8'd0;
                            cursor_y     <= w_y_next;
                        end else if ((char_in == C_BS) && (cursor_x != 8'd0)) begin
                            r_state      <= S_WRITE;
                            write_enable <= 1'b1;
                            addr_write   <= w_cur_addr - ADDR_WIDTH'(1);
                            data_write   <= C_SPACE;
                            busy         <= 1'b1;
                            r_wrap       <= 1'b0;
                            cursor_x     <= cursor_x - 8'd1;
                        end else if (char_in == C_CR) begin
                            cursor_x <= 8'd0;
                        end
                        // BS at column 0 and unknown codes just spend the dead cycle.
                    end else begin
                        char_ready <= 1'b1;
                    end
                end

                S_WRITE: begin
                    if (r_wrap) begin
                        // The cursor already points at the new row, so blank it.
                        r_state      <= S_CLR_LINE;
                        r_cnt        <= '0;
                        write_enable <= 1'b1;
                        addr_write   <= w_row_base;
                        data_write   <= C_SPACE;
                        r_wrap       <= 1'b0;
                    end else begin
                        r_state      <= S_IDLE;
                        write_enable <= 1'b0;
                        char_ready   <= 1'b1;
                        busy         <= 1'b0;
                    end
                end

                S_CLR_LINE: begin
                    if (r_cnt == C_LAST_COL) begin
                        r_state      <= S_IDLE;
                        write_enable <= 1'b0;
                        char_ready   <= 1'b1;
                        busy         <= 1'b0;
                    end else begin
                        r_cnt      <= r_cnt + ADDR_WIDTH'(1);
                        addr_write <= addr_write + ADDR_WIDTH'(1);
                    end
                end

                S_CLR_ALL: begin
                    if (r_cnt == C_LAST_CELL) begin
                        r_state      <= S_IDLE;
                        write_enable <= 1'b0;
                        char_ready   <= 1'b1;
                        busy         <= 1'b0;
                        cursor_x     <= 8'd0;
                        cursor_y     <= 7'd0;
                    end else begin
                        r_cnt      <= r_cnt + ADDR_WIDTH'(1);
                        addr_write <= addr_write + ADDR_WIDTH'(1);
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    write_enable <= 1'b0;
                    char_ready   <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_text_console.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_text_console
//  Description : Scoreboard bench for vga_text_console. The stimulus pushes
//                the expected RAM writes. A negedge monitor pops and compares
//                every write strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_text_console;

    localparam int COLS = 160;
    localparam int ROWS = 128;
    localparam int AW   = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    char_in = 8'd0;
    logic          char_valid = 1'b0;
    logic          char_ready;
    logic          clear_req = 1'b0;
    logic [AW-1:0] addr_write;
    logic [7:0]    data_write;
    logic          write_enable;
    logic [7:0]    cursor_x;
    logic [6:0]    cursor_y;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    logic            sb_on = 1'b1;
    logic [AW+7:0]   exp_q[$];

    vga_text_console #(.COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .clear_req    (clear_req),
        .addr_write   (addr_write),
        .data_write   (data_write),
        .write_enable (write_enable),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: each write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (sb_on && write_enable) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write",
                         addr_write, data_write);
            end else begin
                logic [AW+7:0] e;
                e = exp_q.pop_front();
                if ({addr_write, data_write} !== e) begin
                    failures = failures + 1;
                    $display("FAIL ram_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             addr_write, data_write, e[AW+7:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_w(input int addr, input int data);
        exp_q.push_back({AW'(addr), 8'(data)});
    endtask

    task automatic push_clear_row(input int row);
        for (int c = 0; c < COLS; c++) push_w(row * COLS + c, 8'h20);
    endtask

    task automatic check_cursor(input string name, input int x, input int y);
        chk({name, "_x"}, int'(cursor_x), x);
        chk({name, "_y"}, int'(cursor_y), y);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        char_in    = b;
        char_valid = 1'b1;
        for (int i = 0; i < 30000 && !done; i++) begin
            if (char_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        char_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_idle(output bit saw_busy);
        bit done;
        done     = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 30000 && !done; i++) begin
            if (busy) saw_busy = 1'b1;
            if (!busy && char_ready && !write_enable) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    bit sb;

    initial begin
        @(posedge clk);
        #1;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", int'(write_enable), 0);
        chk("rst_addr", int'(addr_write), 0);
        chk("rst_data", int'(data_write), 0);
        chk("rst_ready", int'(char_ready), 0);
        chk("rst_busy", int'(busy), 0);
        check_cursor("rst_cursor", 0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", int'(char_ready), 1);

        // 1: single printable character
        push_w(0, 8'h41);
        send_byte(8'h41);
        chk("ready_low_after_accept", int'(char_ready), 0);
        wait_idle(sb);
        check_cursor("t1_cursor", 1, 0);
        chk("t1_ready", int'(char_ready), 1);
        chk("t1_drained", exp_q.size(), 0);

        // 2: fill row 0, wrap to row 1 which is blanked
        do_reset();
        for (int i = 0; i < COLS; i++) begin
            push_w(i, 8'h20 + (i % 95));
            send_byte(8'(8'h20 + (i % 95)));
        end
        push_clear_row(1);
        wait_idle(sb);
        chk("t2_busy_seen", int'(sb), 1);
        check_cursor("t2_cursor", 0, 1);
        chk("t2_drained", exp_q.size(), 0);

        // 3: LF on the last row wraps to row 0
        do_reset();
        for (int r = 1; r < ROWS; r++) begin
            push_clear_row(r);
            send_byte(8'h0A);
            wait_idle(sb);
        end
        for (int i = 0; i < 7; i++) begin
            push_w((ROWS - 1) * COLS + i, 8'h61);
            send_byte(8'h61);
        end
        wait_idle(sb);
        check_cursor("t3_pre", 7, 127);
        push_clear_row(0);
        send_byte(8'h0A);
        wait_idle(sb);
        check_cursor("t3_cursor", 0, 0);
        chk("t3_drained", exp_q.size(), 0);

        // 4: backspace, CR and dropped codes on row 2
        push_clear_row(1);
        send_byte(8'h0A);
        wait_idle(sb);
        push_clear_row(2);
        send_byte(8'h0A);
        wait_idle(sb);
        for (int i = 0; i < 5; i++) begin
            push_w(2 * COLS + i, 8'h41 + i);
            send_byte(8'(8'h41 + i));
        end
        wait_idle(sb);
        check_cursor("t4_pre", 5, 2);
        push_w(2 * COLS + 4, 8'h20);
        send_byte(8'h08);
        wait_idle(sb);
        check_cursor("t4_bs", 4, 2);
        for (int i = 3; i >= 0; i--) begin
            push_w(2 * COLS + i, 8'h20);
            send_byte(8'h08);
        end
        wait_idle(sb);
        check_cursor("t4_bs_col0", 0, 2);
        send_byte(8'h08);
        chk("t4_bs0_dead_ready", int'(char_ready), 0);
        chk("t4_bs0_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        chk("t4_bs0_ready_back", int'(char_ready), 1);
        check_cursor("t4_bs0", 0, 2);
        push_w(2 * COLS, 8'h5A);
        send_byte(8'h5A);
        wait_idle(sb);
        send_byte(8'h0D);
        wait_idle(sb);
        check_cursor("t4_cr", 0, 2);
        send_byte(8'h01);
        send_byte(8'h7F);
        send_byte(8'h1F);
        wait_idle(sb);
        check_cursor("t4_dropped", 0, 2);
        push_w(2 * COLS, 8'h7E);
        send_byte(8'h7E);
        wait_idle(sb);
        check_cursor("t4_tilde", 1, 2);
        chk("t4_drained", exp_q.size(), 0);

        // 5: clear_req beats char_valid in the same cycle
        for (int a = 0; a < COLS * ROWS; a++) push_w(a, 8'h20);
        push_w(0, 8'h42);
        char_in    = 8'h42;
        char_valid = 1'b1;
        clear_req  = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        chk("t5_busy", int'(busy), 1);
        chk("t5_ready", int'(char_ready), 0);
        repeat (50) @(posedge clk);
        #1;
        clear_req = 1'b1;          // must be ignored while busy
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        send_byte(8'h42);
        wait_idle(sb);
        check_cursor("t5_cursor", 1, 0);
        chk("t5_drained", exp_q.size(), 0);

        // 6: reset in the middle of a full clear
        sb_on     = 1'b0;
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        chk("t6_mid_addr", int'(addr_write), 1000);
        chk("t6_mid_we", int'(write_enable), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_we", int'(write_enable), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_ready", int'(char_ready), 0);
        check_cursor("t6_rst_cursor", 0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_ready_after", int'(char_ready), 1);
        sb_on = 1'b1;
        push_w(0, 8'h43);
        send_byte(8'h43);
        wait_idle(sb);
        check_cursor("t6_cursor", 1, 0);
        chk("t6_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
